// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared load types, FSM states and limits for the data-memory load unit
package dm_pkg;

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  localparam int MEM_LAT_MAX = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  function automatic logic is_reserved(input logic [2:0] t);
    return t > LT_LHU;
  endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - little-endian byte/halfword select with sign/zero extension and alignment check
module load_extract
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  ltype,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (offset)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    case (ltype)
      LT_LW: begin
        data       = word;
        misaligned = (offset != 2'd0);
      end
      LT_LB:  data = {{24{b[7]}}, b};
      LT_LBU: data = {24'd0, b};
      LT_LH: begin
        data       = {{16{h[15]}}, h};
        misaligned = offset[0];
      end
      LT_LHU: begin
        data       = {16'd0, h};
        misaligned = offset[0];
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dm_load_unit.sv
// rtl/dm_load_unit.sv - single-outstanding load requester for word-addressed data memory; LOAD_TRACE_EN adds a trace print
module dm_load_unit
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [2:0]        req_type,
  input  logic [31:0]       req_pc,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_exc,
  output logic [31:0]       rsp_badvaddr
);

  localparam logic [1:0] LAT_INIT = (MEM_LAT > 0) ? 2'(MEM_LAT - 1) : 2'd0;

  state_e      state, next_state;
  logic [31:0] lat_addr;
  logic [2:0]  lat_type;
  logic [1:0]  cnt;
  logic        accept, capture, illegal, misaligned;
  logic [1:0]  ext_offset;
  logic [2:0]  ext_type;
  logic [31:0] ext_data;

  // In IDLE the extractor looks at the incoming request (alignment check);
  // afterwards it works on the latched request to extract the read word.
  assign ext_offset = (state == IDLE) ? req_addr[1:0] : lat_addr[1:0];
  assign ext_type   = (state == IDLE) ? req_type      : lat_type;

  load_extract u_extract (
    .word       (mem_rdata),
    .offset     (ext_offset),
    .ltype      (ext_type),
    .data       (ext_data),
    .misaligned (misaligned)
  );

  assign illegal      = misaligned | is_reserved(req_type);
  assign mem_addr     = lat_addr[ADDR_W+1:2];
  assign rsp_badvaddr = lat_addr;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    mem_rd_en  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          next_state = illegal ? RESP : READ;
        end
      end
      READ: begin
        mem_rd_en = 1'b1;
        if (MEM_LAT == 0) begin
          capture    = 1'b1;
          next_state = RESP;
        end else begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          capture    = 1'b1;
          next_state = RESP;
        end
      end
      default: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr <= '0;
      lat_type <= LT_LW;
      cnt      <= 2'd0;
      rsp_data <= '0;
      rsp_exc  <= 1'b0;
    end else begin
      if (accept) begin
        lat_addr <= req_addr;
        lat_type <= req_type;
        rsp_exc  <= illegal;
        if (illegal) rsp_data <= '0;
      end
      if (state == READ)                     cnt <= LAT_INIT;
      else if (state == WAIT && cnt != 2'd0) cnt <= cnt - 2'd1;
      if (capture) rsp_data <= ext_data;
    end
  end

`ifdef LOAD_TRACE_EN
  logic [31:0] lat_pc;

  always_ff @(posedge clk) begin
    if (reset) lat_pc <= '0;
    else if (accept) lat_pc <= req_pc;
    if (!reset && capture)
      $display("%d@%h: %h <= *%h", $time, lat_pc, ext_data, {lat_addr[31:2], 2'b00});
    if (!reset && accept && illegal)
      $display("%d@%h: AdEL %h", $time, req_pc, req_addr);
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_load_unit.sv
// tb/tb_dm_load_unit.sv - scoreboard bench for dm_load_unit at MEM_LAT 0, 2 and 3
module tb_dm_load_unit;
  import dm_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready, mem_rd_en, rsp_valid, rsp_exc;
  logic         rsp_ready = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [31:0]  req_pc = '0;
  logic [2:0]   req_type = LT_LW;
  logic [11:0]  mem_addr [N];
  logic [31:0]  mem_rdata [N];
  logic [31:0]  rsp_data [N];
  logic [31:0]  rsp_badvaddr [N];

  logic [31:0]  mem [4096];
  logic [2:0]   pv [N];
  logic [31:0]  pd [N][3];
  int           pulses [N];
  logic [11:0]  strobe_addr [N];

  typedef struct {
    int          inst;
    logic [31:0] data;
    logic        exc;
    logic [31:0] bad;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : (g == 1) ? 2 : 3;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    dm_load_unit #(.ADDR_W(12), .MEM_LAT(g == 0 ? 0 : (g == 1 ? 2 : 3))) u_dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_addr     (req_addr),
      .req_type     (req_type),
      .req_pc       (req_pc),
      .mem_rd_en    (mem_rd_en[g]),
      .mem_addr     (mem_addr[g]),
      .mem_rdata    (mem_rdata[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data[g]),
      .rsp_exc      (rsp_exc[g]),
      .rsp_badvaddr (rsp_badvaddr[g])
    );
  end

  // Memory model: data is valid only during the one cycle MEM_LAT edges after the strobe.
  always @(posedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (mem_rd_en[g]) begin
        pulses[g]      <= pulses[g] + 1;
        strobe_addr[g] <= mem_addr[g];
      end
      pv[g]    <= {pv[g][1:0], mem_rd_en[g]};
      pd[g][0] <= mem[mem_addr[g]];
      pd[g][1] <= pd[g][0];
      pd[g][2] <= pd[g][1];
    end
  end

  always_comb begin
    for (int g = 0; g < N; g++) begin
      mem_rdata[g] = 32'hBAD0_BAD0;
      if (lat_of(g) == 0)             mem_rdata[g] = mem[mem_addr[g]];
      else if (pv[g][lat_of(g) - 1])  mem_rdata[g] = pd[g][lat_of(g) - 1];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      for (int g = 0; g < N; g++) begin
        if (rsp_valid[g] && rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(g), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_inst", 32'(g), 32'(e.inst));
            chk("rsp_data", rsp_data[g], e.data);
            chk("rsp_exc", {31'd0, rsp_exc[g]}, {31'd0, e.exc});
            chk("rsp_badvaddr", rsp_badvaddr[g], e.bad);
          end
        end
      end
    end
  end

  task automatic wait_rsp(input int k, output int n);
    n = 0;
    while (!rsp_valid[k] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release_rsp(input int k, input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_released"}, {30'd0, rsp_valid[k], req_ready[k]}, 32'd1);
  endtask

  task automatic do_load(input int k, input logic [31:0] addr, input logic [2:0] t,
                         input logic [31:0] data, input logic exc, input logic [11:0] widx,
                         input string tag);
    int n, p0;
    exp_q.push_back('{k, data, exc, addr});
    p0 = pulses[k];
    req_addr = addr;
    req_type = t;
    req_pc   = 32'h0000_1000 + addr;
    req_valid[k] = 1'b1;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    wait_rsp(k, n);
    chk({tag, "_latency"}, 32'(n), exc ? 32'd0 : 32'(1 + lat_of(k)));
    chk({tag, "_rd_pulses"}, 32'(pulses[k] - p0), exc ? 32'd0 : 32'd1);
    if (!exc) chk({tag, "_mem_addr"}, {20'd0, strobe_addr[k]}, {20'd0, widx});
    release_rsp(k, tag);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[3] = 32'h8001_F27F;
    mem[4] = 32'hDEAD_BEEF;
    for (int g = 0; g < N; g++) pulses[g] = 0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("reset_req_ready", {31'd0, req_ready[0]}, 32'd1);
    chk("reset_mem_rd_en", {31'd0, mem_rd_en[0]}, 32'd0);
    chk("reset_mem_addr", {20'd0, mem_addr[0]}, 32'd0);
    chk("reset_rsp_data", rsp_data[0], 32'd0);
    chk("reset_rsp_exc", {31'd0, rsp_exc[0]}, 32'd0);
    chk("reset_badvaddr", rsp_badvaddr[0], 32'd0);

    do_load(0, 32'h0000_000C, LT_LB,  32'h0000_007F, 1'b0, 12'd3, "lb_c");
    do_load(0, 32'h0000_000D, LT_LB,  32'hFFFF_FFF2, 1'b0, 12'd3, "lb_d");
    do_load(0, 32'h0000_000D, LT_LBU, 32'h0000_00F2, 1'b0, 12'd3, "lbu_d");
    do_load(0, 32'h0000_000E, LT_LH,  32'hFFFF_8001, 1'b0, 12'd3, "lh_e");
    do_load(0, 32'h0000_000E, LT_LHU, 32'h0000_8001, 1'b0, 12'd3, "lhu_e");
    do_load(0, 32'h0000_000C, LT_LW,  32'h8001_F27F, 1'b0, 12'd3, "lw_c");
    do_load(0, 32'h0000_400C, LT_LB,  32'h0000_007F, 1'b0, 12'd3, "lb_wrap");
    do_load(0, 32'h0000_0006, LT_LW,  32'h0000_0000, 1'b1, 12'd0, "lw_mis");
    do_load(0, 32'h0000_000D, LT_LH,  32'h0000_0000, 1'b1, 12'd0, "lh_mis");
    do_load(0, 32'h0000_000C, 3'b111, 32'h0000_0000, 1'b1, 12'd0, "rsvd");
    do_load(1, 32'h0000_0010, LT_LW,  32'hDEAD_BEEF, 1'b0, 12'd4, "lw_lat2");
    do_load(2, 32'h0000_0010, LT_LW,  32'hDEAD_BEEF, 1'b0, 12'd4, "lw_lat3");

    // Backpressure: response held, a second request waits until after the release edge.
    exp_q.push_back('{0, 32'h0000_00F2, 1'b0, 32'h0000_000D});
    exp_q.push_back('{0, 32'h0000_007F, 1'b0, 32'h0000_000C});
    req_addr = 32'h0000_000D; req_type = LT_LBU; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(0, n);
    chk("stall_first_latency", 32'(n), 32'd1);
    req_addr = 32'h0000_000C; req_type = LT_LB; req_valid[0] = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
      chk("stall_rsp_data", rsp_data[0], 32'h0000_00F2);
      chk("stall_badvaddr", rsp_badvaddr[0], 32'h0000_000D);
      chk("stall_req_ready", {31'd0, req_ready[0]}, 32'd0);
    end
    release_rsp(0, "stall");
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("stall_second_accepted", {31'd0, req_ready[0]}, 32'd0);
    wait_rsp(0, n);
    chk("stall_second_latency", 32'(n), 32'd1);
    release_rsp(0, "stall2");

    // Reset in WAIT aborts the load; the late memory data must not surface.
    req_addr = 32'h0000_0010; req_type = LT_LW; req_valid[2] = 1'b1;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_wait", {30'd0, mem_rd_en[2], req_ready[2]}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_rsp_valid", {31'd0, rsp_valid[2]}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready[2]}, 32'd1);
    n = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid[2]) n++;
    end
    chk("abort_no_rsp", 32'(n), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
